// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: digit/segment types and active-high 7-segment codes {g,f,e,d,c,b,a}.
package seven_seg_pkg;
    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to active-high segment pattern; non-decimal codes blank.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  bcd_t digit,
    output seg_t seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/count_display_scan.sv
// count_display_scan: shows a 0..15 count as two multiplexed 7-seg digits, latched once per frame.
// Optional COUNT_DISPLAY_BLANK_LEADING_ZERO_EN blanks the tens slot when it is zero.
module count_display_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic [3:0] Count,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam seg_t          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]    AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [CW-1:0] refresh_cnt;
    logic          digit_idx;
    logic [3:0]    snapshot;
    logic          wrap;
    logic          tens;
    bcd_t          ones;
    bcd_t          digit;
    seg_t          pattern;
    seg_t          seg_d;
    logic [1:0]    an_d;

    assign wrap  = refresh_cnt == LAST;
    assign tens  = snapshot >= 4'd10;
    assign ones  = tens ? snapshot - 4'd10 : snapshot;
    assign digit = digit_idx ? {3'b000, tens} : ones;
    assign an_d  = digit_idx ? 2'b10 : 2'b01;

    bcd_to_seg u_bcd_to_seg (
        .digit(digit),
        .seg  (pattern)
    );

`ifdef COUNT_DISPLAY_BLANK_LEADING_ZERO_EN
    assign seg_d = (digit_idx && !tens) ? SEG_BLANK : pattern;
`else
    assign seg_d = pattern;
`endif

    // Count is only sampled at the end of the tens slot, so both digits of a frame agree.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 1'b0;
            snapshot    <= 4'd0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            if (wrap) digit_idx <= ~digit_idx;
            if (wrap && digit_idx) snapshot <= Count;
            seg <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
            an  <= SEG_ACTIVE_LOW ? ~an_d : an_d;
        end
    end
endmodule

// File: doc/count_display_scan.md
Name: count_display_scan

Overview:
- Downstream consumer of the 4-bit up/down counter. Takes its 4-bit Count (0..15) and drives a 2-digit multiplexed 7-segment display showing decimal "00".."15".
- Converts binary to two BCD digits and time-multiplexes the two digits with a refresh divider.
- Latches Count once per scan frame, so both digits always show the same value (no tearing).

Parameters:
REFRESH_DIV, 50000, Clk cycles each digit stays lit; legal range >= 2.
SEG_ACTIVE_LOW, 1, 1 = seg and an outputs are active-low (common-anode board); 0 = active-high.

Ports:
Clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-low (asserted when 0).
Count  input  4  binary value from the up/down counter, synchronous to Clk.
seg  output  7  segment drive {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
an  output  2  digit enables; an[0] = ones digit, an[1] = tens digit; polarity per SEG_ACTIVE_LOW.

Behaviour:
- Reset (rst=0, async, no clock needed) clears these internal registers: refresh counter = 0, digit_idx = 0, snapshot = 0.
- Reset drives both digits off: an = 2'b11 (active-low) / 2'b00 (active-high).
- Reset drives all segments off: seg = 7'h7F (active-low) / 7'h00 (active-high).
- Refresh counter: width $clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1, then wraps to 0.
- On the wrap edge, digit_idx toggles.
- Frame boundary = wrap edge while digit_idx==1. On that edge, snapshot <= Count. Count is not sampled at any other time.
- A Count change mid-frame has no effect until the next frame boundary, even if Count changes several times.
- BCD split (combinational from snapshot):
  - snapshot >= 10: tens = 1, ones = snapshot - 10.
  - otherwise: tens = 0, ones = snapshot.
- Segment codes, active-high form: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex). Any code above 9 is unreachable; it decodes to blank.
- seg and an are registered. They are updated every Clk edge from the current digit_idx and snapshot, so they lag a digit_idx change by exactly 1 cycle.
- Only one an bit is ever active. Both are inactive only during reset and the first edge after reset release.
- digit_idx=0 selects the ones digit; digit_idx=1 selects the tens digit.
- When SEG_ACTIVE_LOW=1, the active-high patterns for seg and an are bitwise inverted before the output register.
- Upstream wrap-around (15->0, 0->15) needs no special handling; each value is displayed exactly as latched.
- Worst-case latency from a Count change to the display: 2*REFRESH_DIV+1 cycles.
- Reset asserted mid-scan: outputs blank immediately. After release, scanning restarts at the ones digit with snapshot 0.

Optional Feature:
- Macro: COUNT_DISPLAY_BLANK_LEADING_ZERO_EN.
- Defined: when tens==0, the tens digit slot drives all segments off (an still strobes, keeping timing uniform).
- Not defined: the tens digit shows "0" (code 3F).
- The ones digit is never blanked.

Decomposition:
- Package seven_seg_pkg holds:
  - the 10 segment code constants;
  - the SEG_BLANK constant;
  - a typedef for a 4-bit BCD digit;
  - a typedef for the 7-bit segment vector.
- Sub-module bcd_to_seg: combinational, 4-bit BCD in, 7-bit active-high pattern out. The top module instantiates it once, on the muxed digit.

Test Plan:
- All cases below use REFRESH_DIV=4 and SEG_ACTIVE_LOW=1.
- Hold rst=0 for 3 cycles with Count=9 -> an=2'b11, seg=7'h7F throughout; snapshot stays 0.
- Release rst, Count=7 -> first frame shows ones "0" (an=2'b10, seg=7'h40) and tens "0" (an=2'b01, seg=7'h40, or 7'h7F with the macro). From cycle 9 onward the ones digit shows 7 (seg=7'h78).
- Count=15 steady -> alternating 4-cycle windows: an=2'b10 with seg=7'h12 ("5"), and an=2'b01 with seg=7'h79 ("1").
- Count steps 15->0->1 mid-frame while the ones digit is lit -> display keeps "15" until the frame boundary, then shows "01" (the last sampled value); never a mixed value such as "10".
- Pulse rst low for half a cycle mid-scan -> an and seg blank asynchronously before the next edge; after release, ones digit first, showing 0.
- With SEG_ACTIVE_LOW=0 and Count=12 -> an=2'b01 with seg=7'h5B, and an=2'b10 with seg=7'h06.
